// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative RISC-V M-extension multiply/divide unit for the EX stage.
// It takes one operation at a time over a valid/ready handshake and runs a radix-2
// shift-add (multiply) or restoring-divide loop for DWIDTH cycles. A one-cycle
// fix-up stage then applies the sign and picks the output word. The result and its
// tag are held until the pipeline takes them. flush aborts whatever is in flight.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operation handshake (in_ready = unit idle)
//   mdop                 funct3: MUL MULH MULHSU MULHU DIV DIVU REM REMU
//   op1, op2             rs1 / rs2 operands
//   in_tag               routing tag captured with the operation
//   flush                synchronous abort, highest priority
//   out_valid/out_ready  result handshake
//   out_result, out_tag  registered result and its tag
module alu_muldiv #(
  parameter int DWIDTH = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        mdop,
  input  logic [DWIDTH-1:0] op1,
  input  logic [DWIDTH-1:0] op2,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int CW = $clog2(DWIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, FIXUP, DONE} state_t;

  state_t              state;
  logic [2:0]          op_q;
  logic [TAG_W-1:0]    tag_q;
  logic [DWIDTH-1:0]   opnd_q;  // multiplicand or divisor magnitude
  logic [2*DWIDTH-1:0] acc_q;   // mul: {hi, lo/multiplier}; div: {remainder, quotient}
  logic                sign_q;
  logic [CW-1:0]       cnt_q;

  assign in_ready = (state == IDLE);

  // ---------------- operand decode (IDLE only) ----------------
  logic              is_div, op1_sgn, op2_sgn, s1, s2, sign_d;
  logic              div_zero, div_ovf, special;
  logic [DWIDTH-1:0] mag1, mag2;

  always_comb begin
    is_div   = mdop[2];
    op1_sgn  = mdop[2] ? !mdop[0] : (mdop[1:0] != 2'b11);
    op2_sgn  = mdop[2] ? !mdop[0] : !mdop[1];
    s1       = op1_sgn & op1[DWIDTH-1];
    s2       = op2_sgn & op2[DWIDTH-1];
    mag1     = s1 ? -op1 : op1;
    mag2     = s2 ? -op2 : op2;
    // remainder follows the dividend; MULHSU gets s2 = 0 so s1^s2 covers it
    sign_d   = (mdop[2] & mdop[1]) ? s1 : (s1 ^ s2);
    div_zero = is_div && (op2 == '0);
    div_ovf  = is_div && !mdop[0] && (op1 == {1'b1, {(DWIDTH-1){1'b0}}}) && (op2 == '1);
    special  = div_zero | div_ovf;
  end

  // ---------------- one iteration ----------------
  logic [DWIDTH:0]     mul_sum, div_sh, div_diff;
  logic [2*DWIDTH-1:0] mul_next, div_next;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*DWIDTH-1:DWIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[DWIDTH-1:1]};
    // remainder shifted left, pulling in the next dividend bit
    div_sh   = acc_q[2*DWIDTH-1:DWIDTH-1];
    div_diff = div_sh - {1'b0, opnd_q};
    div_next = !div_diff[DWIDTH] ? {div_diff[DWIDTH-1:0], acc_q[DWIDTH-2:0], 1'b1}
                                 : {div_sh[DWIDTH-1:0],   acc_q[DWIDTH-2:0], 1'b0};
  end

  // ---------------- sign fix-up and word select ----------------
  logic [2*DWIDTH-1:0] mul_fin;
  logic [DWIDTH-1:0]   div_pick, div_fin, fix_res;

  always_comb begin
    mul_fin  = sign_q ? -acc_q : acc_q;
    div_pick = op_q[1] ? acc_q[2*DWIDTH-1:DWIDTH] : acc_q[DWIDTH-1:0];
    div_fin  = sign_q ? -div_pick : div_pick;
    if (op_q[2])                fix_res = div_fin;
    else if (op_q[1:0] == 2'b00) fix_res = mul_fin[DWIDTH-1:0];
    else                        fix_res = mul_fin[2*DWIDTH-1:DWIDTH];
  end

  // ---------------- control ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= '0;
      tag_q      <= '0;
      opnd_q     <= '0;
      acc_q      <= '0;
      sign_q     <= 1'b0;
      cnt_q      <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_q   <= mdop;
          tag_q  <= in_tag;
          cnt_q  <= CW'(DWIDTH);
          opnd_q <= is_div ? mag2 : mag1;
          if (special) begin
            // Preload the final {remainder, quotient} so the fix-up stage just
            // registers it: div-by-zero gives {op1, all-ones}, overflow {0, op1}.
            acc_q  <= div_zero ? {op1, {DWIDTH{1'b1}}} : {{DWIDTH{1'b0}}, op1};
            sign_q <= 1'b0;
            state  <= FIXUP;
          end else begin
            acc_q  <= {{DWIDTH{1'b0}}, (is_div ? mag1 : mag2)};
            sign_q <= sign_d;
            state  <= BUSY;
          end
        end
        BUSY: begin
          acc_q <= op_q[2] ? div_next : mul_next;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state <= FIXUP;
        end
        FIXUP: begin
          out_result <= fix_res;
          out_tag    <= tag_q;
          out_valid  <= 1'b1;
          state      <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: a DWIDTH=32 instance (directed cases, backpressure,
// flush, reset, random) and a DWIDTH=8 instance (random sweep) run side by side.
module tb_alu_muldiv;

  localparam int TW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [63:0]   res;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];

  // ---------------- DUT 32 ----------------
  logic          rst32_n = 1'b0, iv32 = 1'b0, fl32 = 1'b0, ordy32 = 1'b1;
  logic          ir32, ov32;
  logic [2:0]    op32 = '0;
  logic [31:0]   a32 = '0, b32 = '0, res32;
  logic [TW-1:0] tag32 = '0, otag32;

  alu_muldiv #(.DWIDTH(32), .TAG_W(TW)) dut32 (
    .clk(clk), .rst_n(rst32_n), .in_valid(iv32), .in_ready(ir32), .mdop(op32),
    .op1(a32), .op2(b32), .in_tag(tag32), .flush(fl32), .out_valid(ov32),
    .out_ready(ordy32), .out_result(res32), .out_tag(otag32));

  // ---------------- DUT 8 ----------------
  logic          rst8_n = 1'b0, iv8 = 1'b0, fl8 = 1'b0, ordy8 = 1'b1;
  logic          ir8, ov8;
  logic [2:0]    op8 = '0;
  logic [7:0]    a8 = '0, b8 = '0, res8;
  logic [TW-1:0] tag8 = '0, otag8;

  alu_muldiv #(.DWIDTH(8), .TAG_W(TW)) dut8 (
    .clk(clk), .rst_n(rst8_n), .in_valid(iv8), .in_ready(ir8), .mdop(op8),
    .op1(a8), .op2(b8), .in_tag(tag8), .flush(fl8), .out_valid(ov8),
    .out_ready(ordy8), .out_result(res8), .out_tag(otag8));

  // ---------------- reference model ----------------
  // Plain signed arithmetic on wide integers, reduced modulo 2^w.
  function automatic logic [63:0] ref_calc(input logic [2:0] op, input logic [63:0] a,
                                           input logic [63:0] b, input int w);
    logic signed [129:0] one, x, y, p, t;
    logic [63:0] m;
    bit sa, sb;
    one = 130'sd1;
    m   = 64'((one << w) - one);
    sa  = (op != 3'd3) && (op != 3'd5) && (op != 3'd7);
    sb  = (op == 3'd0) || (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    x = '0; x[63:0] = a & m; if (sa && x[w-1]) x = x - (one << w);
    y = '0; y[63:0] = b & m; if (sb && y[w-1]) y = y - (one << w);
    if (!op[2]) begin
      p = x * y;
      t = (op == 3'd0) ? p : (p >>> w);
      return t[63:0] & m;
    end
    if (y == 0) return op[1] ? (a & m) : m;
    if (sa && y == -one && x == -(one << (w - 1))) return op[1] ? 64'd0 : (a & m);
    t = op[1] ? (x % y) : (x / y);
    return t[63:0] & m;
  endfunction

  function automatic logic [63:0] pick(input int w);
    logic [63:0] m, r;
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    r = {$urandom, $urandom};
    case ($urandom_range(0, 9))
      0: return 64'd0;
      1: return m;
      2: return 64'd1 << (w - 1);
      3: return 64'd1;
      4: return 64'($urandom_range(0, 15));
      default: return r & m;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    exp_t e;
    if (rst32_n && ov32 && ordy32) begin
      if (q32.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL mon32_unexpected: got result %0h, expected none", res32);
      end else begin
        e = q32.pop_front();
        chk("mon32_result", 64'(res32), e.res);
        chk("mon32_tag", 64'(otag32), 64'(e.tag));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst8_n && ov8 && ordy8) begin
      if (q8.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL mon8_unexpected: got result %0h, expected none", res8);
      end else begin
        e = q8.pop_front();
        chk("mon8_result", 64'(res8), e.res);
        chk("mon8_tag", 64'(otag8), 64'(e.tag));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic issue32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TW-1:0] tg, input bit push, input logic [31:0] exp);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    iv32 = 1'b1; op32 = op; a32 = a; b32 = b; tag32 = tg;
    while (!ir32 && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) begin
      n_checks++; n_fail++;
      $display("FAIL issue32_timeout: in_ready stayed 0, expected 1");
      iv32 = 1'b0;
      return;
    end
    if (push) begin e.res = 64'(exp); e.tag = tg; q32.push_back(e); end
    @(posedge clk); #1 iv32 = 1'b0;
  endtask

  task automatic issue8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [TW-1:0] tg, input logic [7:0] exp);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    iv8 = 1'b1; op8 = op; a8 = a; b8 = b; tag8 = tg;
    while (!ir8 && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) begin
      n_checks++; n_fail++;
      $display("FAIL issue8_timeout: in_ready stayed 0, expected 1");
      iv8 = 1'b0;
      return;
    end
    e.res = 64'(exp); e.tag = tg; q8.push_back(e);
    @(posedge clk); #1 iv8 = 1'b0;
  endtask

  // edges after the accept edge until out_valid is first seen high
  task automatic wait_valid32(output int n);
    n = 0;
    do begin @(posedge clk); n++; @(negedge clk); end while (!ov32 && n < 200);
  endtask

  // random out_ready backpressure
  bit rnd32_on = 1'b0;
  bit done8    = 1'b0;
  initial forever begin
    @(posedge clk); #1;
    if (rnd32_on) ordy32 = ($urandom_range(0, 3) != 0);
    ordy8 = ($urandom_range(0, 3) != 0);
  end

  // watchdog
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT 8 random sweep ----------------
  initial begin
    logic [2:0]  op;
    logic [63:0] a, b;
    int n;
    @(posedge rst8_n);
    for (int i = 0; i < 2500; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick(8);
      b  = pick(8);
      issue8(op, a[7:0], b[7:0], TW'($urandom), ref_calc(op, a, b, 8)[7:0]);
    end
    n = 0;
    while (q8.size() != 0 && n < 500) begin @(negedge clk); n++; end
    chk("q8_drained", 64'(q8.size()), 64'd0);
    done8 = 1'b1;
  end

  // ---------------- DUT 32 directed + random ----------------
  logic [2:0]  d_op  [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                              3'd4, 3'd7, 3'd4, 3'd6};
  logic [31:0] d_a   [12] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'hFFFFFFF9,
                              32'd5, 32'd5, 32'h80000000, 32'h80000000};
  logic [31:0] d_b   [12] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'd2, 32'd2, 32'd2, 32'd2,
                              32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] d_exp [12] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF,
                              32'hFFFFFFFD, 32'hFFFFFFFF, 32'd3, 32'd1,
                              32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
  int          d_lat [12] = '{33, 33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1};

  initial begin
    int n, cnt;
    logic [2:0]  op;
    logic [63:0] a, b;

    #3;
    chk("rst32_in_ready", 64'(ir32), 64'd1);
    chk("rst32_out_valid", 64'(ov32), 64'd0);
    chk("rst32_out_result", 64'(res32), 64'd0);
    chk("rst32_out_tag", 64'(otag32), 64'd0);
    chk("rst8_in_ready", 64'(ir8), 64'd1);
    chk("rst8_out_valid", 64'(ov8), 64'd0);
    #9 rst32_n = 1'b1; rst8_n = 1'b1;

    // directed results with first-valid latency
    for (int i = 0; i < 12; i++) begin
      issue32(d_op[i], d_a[i], d_b[i], TW'(i + 9), 1'b1, d_exp[i]);
      wait_valid32(n);
      chk($sformatf("latency_%0d", i), 64'(n), 64'(d_lat[i]));
    end

    // backpressure: result held for 10 cycles
    @(posedge clk); #1 ordy32 = 1'b0;
    issue32(3'd5, 32'd100, 32'd7, TW'(3), 1'b1, 32'd14);
    wait_valid32(n);
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", 64'(ov32), 64'd1);
      chk("bp_out_result", 64'(res32), 64'd14);
      chk("bp_out_tag", 64'(otag32), 64'd3);
      chk("bp_in_ready", 64'(ir32), 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1 ordy32 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("retire_in_ready", 64'(ir32), 64'd1);
    chk("retire_out_valid", 64'(ov32), 64'd0);

    // flush in the 10th BUSY cycle
    issue32(3'd0, 32'd3, 32'd5, TW'(4), 1'b0, 32'd0);
    repeat (9) @(posedge clk);
    #1 fl32 = 1'b1;
    @(posedge clk); #1 fl32 = 1'b0;
    @(negedge clk);
    chk("flush_in_ready", 64'(ir32), 64'd1);
    chk("flush_out_valid", 64'(ov32), 64'd0);
    // in_valid during a flush cycle is ignored
    fl32 = 1'b1; iv32 = 1'b1; op32 = 3'd0; a32 = 32'd2; b32 = 32'd2;
    @(posedge clk); #1 fl32 = 1'b0; iv32 = 1'b0;
    @(negedge clk);
    chk("flush_blocks_accept", 64'(ir32), 64'd1);
    cnt = 0;
    repeat (40) begin @(negedge clk); if (ov32) cnt++; end
    chk("flush_no_output", 64'(cnt), 64'd0);
    issue32(3'd0, 32'd6, 32'd7, TW'(12), 1'b1, 32'd42);
    wait_valid32(n);
    chk("post_flush_latency", 64'(n), 64'd33);

    // asynchronous reset mid-BUSY
    @(negedge clk);
    issue32(3'd5, 32'd1000, 32'd3, TW'(7), 1'b0, 32'd0);
    repeat (5) @(posedge clk);
    #2 rst32_n = 1'b0;
    #1;
    chk("areset_in_ready", 64'(ir32), 64'd1);
    chk("areset_out_valid", 64'(ov32), 64'd0);
    chk("areset_out_result", 64'(res32), 64'd0);
    chk("areset_out_tag", 64'(otag32), 64'd0);
    @(negedge clk) rst32_n = 1'b1;
    cnt = 0;
    repeat (40) begin @(negedge clk); if (ov32) cnt++; end
    chk("areset_no_output", 64'(cnt), 64'd0);

    // random sweep with backpressure
    rnd32_on = 1'b1;
    for (int i = 0; i < 300; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick(32);
      b  = pick(32);
      issue32(op, a[31:0], b[31:0], TW'($urandom), 1'b1, ref_calc(op, a, b, 32)[31:0]);
    end
    n = 0;
    while (q32.size() != 0 && n < 500) begin @(negedge clk); n++; end
    rnd32_on = 1'b0;
    chk("q32_drained", 64'(q32.size()), 64'd0);

    n = 0;
    while (!done8 && n < 60000) begin @(negedge clk); n++; end
    chk("dut8_sweep_done", 64'(done8), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
